instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Fetch stage: owns the program counter, issues one word-aligned read at a time to instruction memory, and presents the returned 32-bit instruction to the decode/flags stage.
- Consumes the decode result (branch_select qualified by ALU zero, jump_select) at the instruction handshake to compute the next PC.
- Single outstanding fetch, no speculation, so no flush path is required.
- Sticky fault on memory error or response timeout.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- TIMEOUT, 16, maximum cycles spent in WAIT before fault; range 2..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active low.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  32  byte address of the read; equals pc; bits [1:0] are always 0.
- imem_rsp_valid  in  1  read data valid.
- imem_rsp_data  in  32  instruction word.
- imem_rsp_err  in  1  error flag, qualified by imem_rsp_valid.
- instr_valid  out  1  instr and instr_pc are valid.
- instr_ready  in  1  decode/execute has completed the instruction.
- instr  out  32  held instruction word.
- instr_pc  out  32  address of instr.
- branch_taken  in  1  branch_select AND zero; sampled only on instr handshake.
- jump_taken  in  1  jump_select; sampled only on instr handshake.
- fault  out  1  sticky fault indicator.
- fetch_count  out  32  number of completed instruction handshakes; wraps.

Behaviour:
- Reset values: pc=RESET_PC, state=REQ, imem_req_valid=0 during reset, instr_valid=0, instr=0, instr_pc=0, fault=0, fetch_count=0, timeout counter=0.
- States: REQ, WAIT, HOLD, FAULT. All state outputs are registered, except that imem_addr is driven directly from pc.
- REQ:
  - imem_req_valid=1 and imem_addr=pc.
  - On imem_req_ready=1, go to WAIT and clear the timeout counter.
  - imem_req_valid is not deasserted until accepted.
- WAIT:
  - imem_req_valid=0; the timeout counter increments each cycle.
  - On imem_rsp_valid with err=0: latch instr=imem_rsp_data and instr_pc=pc, go to HOLD. instr_valid rises the next cycle.
  - On imem_rsp_valid with err=1: go to FAULT.
  - If the counter reaches TIMEOUT with no response: go to FAULT.
  - A response and a timeout in the same cycle: the response wins.
- Responses outside WAIT are ignored. Memory never responds in the cycle the request is accepted.
- HOLD:
  - instr_valid=1; instr and instr_pc stay stable until handshake.
  - On instr_ready=1: pc <= next_pc, fetch_count++, go to REQ.
  - Minimum loop is 3 cycles per instruction (REQ accept, WAIT 1, HOLD 1).
- next_pc, with pc4 = instr_pc + 4 (32-bit, wraps at 2^32):
  - jump_taken: {pc4[31:28], instr[25:0], 2'b00}.
  - else branch_taken: pc4 + ({{14{instr[15]}}, instr[15:0], 2'b00}), modulo 2^32.
  - else: pc4.
  - If both are set, jump has priority.
- FAULT:
  - Terminal until reset. fault=1, imem_req_valid=0, instr_valid=0.
  - pc is frozen at the faulting address.
- Reset asserted mid-transaction: state returns to reset values immediately. Any later stale response arrives in REQ and is ignored.

Decomposition:
- Shared package (cpu_pkg):
  - Opcode constants: OP_RTYPE 6'b000000, OP_LW 6'b100011, OP_SW 6'b101011, OP_BEQ 6'b000100, OP_J 6'b000010.
  - Funct constants: 100000, 100010, 100100, 100101.
  - fetch_state_t enum.
  - Width constant WORD_W=32.
- One combinational sub-module, next_pc_calc, with inputs instr_pc, instr, branch_taken, jump_taken and output next_pc. The same module is reusable by the execute stage.

Test Plan:
- Reset release, memory always ready, 1-cycle response -> first imem_addr=0x0. Next fetch addresses are 0x4, then 0x8. fetch_count=2 after two handshakes.
- beq with imem_rsp_data=0x1000FFFF at pc 0x10, branch_taken=1 -> next imem_addr=0x10 (0x14 - 4). With branch_taken=0 -> next imem_addr=0x14.
- j with instr=0x08000040 at pc 0x10000008 -> next imem_addr=0x10000100. With jump_taken=branch_taken=1 -> jump target used.
- instr_ready low for 3 cycles in HOLD -> instr_valid stays 1, instr and instr_pc unchanged, no new imem_req_valid. One cycle after instr_ready=1, imem_req_valid=1.
- imem_req_ready low for 5 cycles -> imem_req_valid held at 1 and imem_addr stable. Then a response with err=1 -> fault=1 next cycle, no further requests until rst_n pulse. After reset, imem_addr=RESET_PC.
- No response for TIMEOUT=16 cycles -> fault=1. A response arriving on exactly the 16th cycle -> HOLD, fault=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the small CPU pipeline: datapath width, MIPS-style
// opcode and funct encodings used by decode/execute, and the fetch-stage
// state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int WORD_W = 32;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct field (instr[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;

    typedef enum logic [1:0] {
        FS_REQ   = 2'd0,
        FS_WAIT  = 2'd1,
        FS_HOLD  = 2'd2,
        FS_FAULT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// ---------------------------------------------------------------------------
// next_pc_calc
// Purely combinational successor-PC computation, shared by fetch and execute.
// Ports:
//   instr_pc     in  32  address of the instruction being retired
//   instr        in  32  the instruction word (jump target / branch offset)
//   branch_taken in  1   branch condition resolved true
//   jump_taken   in  1   unconditional jump; overrides branch_taken
//   next_pc      out 32  address of the next instruction to fetch
// ---------------------------------------------------------------------------
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [WORD_W-1:0] instr_pc,
    input  logic [WORD_W-1:0] instr,
    input  logic              branch_taken,
    input  logic              jump_taken,
    output logic [WORD_W-1:0] next_pc
);

    logic [WORD_W-1:0] pc4;
    logic [WORD_W-1:0] branchOffset;
    logic              unusedOpcode;

    assign pc4          = instr_pc + 32'd4;
    // Word offset, sign-extended and scaled to bytes.
    assign branchOffset = {{14{instr[15]}}, instr[15:0], 2'b00};
    // The opcode bits are decoded elsewhere; only the immediate fields matter here.
    assign unusedOpcode = ^instr[31:26];

    // Jump keeps the 256 MB region of the delay-free successor address.
    always_comb begin
        next_pc = pc4;
        if (jump_taken) begin
            next_pc = {pc4[31:28], instr[25:0], 2'b00};
        end else if (branch_taken) begin
            next_pc = pc4 + branchOffset;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Fetch stage: owns the PC, issues one word read at a time to instruction
// memory, holds the returned word for decode, and computes the next PC from
// the decode result at the instruction handshake. Any memory error or
// response timeout parks the stage in a sticky fault until reset.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   imem_req_valid/ready  read request handshake
//   imem_addr             read byte address (= pc, word aligned)
//   imem_rsp_valid/data/err  read response
//   instr_valid/ready     instruction handshake toward decode
//   instr, instr_pc       held instruction word and its address
//   branch_taken, jump_taken  decode result, sampled at instr handshake
//   fault                 sticky fault indicator
//   fetch_count           completed instruction handshakes (wraps)
// ---------------------------------------------------------------------------
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned       TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [WORD_W-1:0] imem_rsp_data,
    input  logic              imem_rsp_err,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc,
    input  logic              branch_taken,
    input  logic              jump_taken,
    output logic              fault,
    output logic [WORD_W-1:0] fetch_count
);

    localparam logic [7:0]        TIMEOUT_CNT  = 8'(TIMEOUT);
    localparam logic [WORD_W-1:0] RESET_PC_AL  = {RESET_PC[WORD_W-1:2], 2'b00};

    fetch_state_t      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] instrPc_q, instrPc_d;
    logic [WORD_W-1:0] fetchCount_q, fetchCount_d;
    logic [7:0]        timeoutCnt_q, timeoutCnt_d;
    logic              reqValid_q, reqValid_d;
    logic              instrValid_q, instrValid_d;
    logic              fault_q, fault_d;
    logic [WORD_W-1:0] nextPc;

    next_pc_calc u_nextPc (
        .instr_pc     (instrPc_q),
        .instr        (instr_q),
        .branch_taken (branch_taken),
        .jump_taken   (jump_taken),
        .next_pc      (nextPc)
    );

    // Next-state logic. The handshake outputs are registered copies of the
    // next state, so the request only goes out from the second cycle after
    // reset and acceptance is qualified by the registered valid.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        instrPc_d    = instrPc_q;
        fetchCount_d = fetchCount_q;
        timeoutCnt_d = timeoutCnt_q;

        case (state_q)
            FS_REQ: begin
                if (reqValid_q && imem_req_ready) begin
                    state_d      = FS_WAIT;
                    timeoutCnt_d = '0;
                end
            end
            FS_WAIT: begin
                timeoutCnt_d = timeoutCnt_q + 8'd1;
                // A response beats a timeout landing in the same cycle.
                if (imem_rsp_valid) begin
                    if (imem_rsp_err) begin
                        state_d = FS_FAULT;
                    end else begin
                        instr_d   = imem_rsp_data;
                        instrPc_d = pc_q;
                        state_d   = FS_HOLD;
                    end
                end else if (timeoutCnt_d == TIMEOUT_CNT) begin
                    state_d = FS_FAULT;
                end
            end
            FS_HOLD: begin
                if (instr_ready) begin
                    pc_d         = nextPc;
                    fetchCount_d = fetchCount_q + 32'd1;
                    state_d      = FS_REQ;
                end
            end
            FS_FAULT: begin
                state_d = FS_FAULT;
            end
            default: begin
                state_d = FS_FAULT;
            end
        endcase

        reqValid_d   = (state_d == FS_REQ);
        instrValid_d = (state_d == FS_HOLD);
        fault_d      = (state_d == FS_FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FS_REQ;
            pc_q         <= RESET_PC_AL;
            instr_q      <= '0;
            instrPc_q    <= '0;
            fetchCount_q <= '0;
            timeoutCnt_q <= '0;
            reqValid_q   <= 1'b0;
            instrValid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            instrPc_q    <= instrPc_d;
            fetchCount_q <= fetchCount_d;
            timeoutCnt_q <= timeoutCnt_d;
            reqValid_q   <= reqValid_d;
            instrValid_q <= instrValid_d;
            fault_q      <= fault_d;
        end
    end

    assign imem_req_valid = reqValid_q;
    assign imem_addr      = pc_q;
    assign instr_valid    = instrValid_q;
    assign instr          = instr_q;
    assign instr_pc       = instrPc_q;
    assign fault          = fault_q;
    assign fetch_count    = fetchCount_q;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Bench for instr_fetch. The bench plays both instruction memory and decode.
// Each driven response pushes the expected {instr, instr_pc} into a queue,
// which is popped when the fetch stage presents instr_valid. Next-PC results
// are checked as the address of the following request.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } expect_t;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        branch_taken;
    logic        jump_taken;
    logic        fault;
    logic [31:0] fetch_count;

    expect_t expQ[$];
    int      passCount = 0;
    int      checkCount = 0;
    int      expFetchCount = 0;

    instr_fetch #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .branch_taken   (branch_taken),
        .jump_taken     (jump_taken),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    // Free-running 10 ns clock; inputs change and outputs are sampled on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so a stuck design can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic doReset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        instr_ready    = 1'b0;
        branch_taken   = 1'b0;
        jump_taken     = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("rst_imem_addr", imem_addr, 32'h0000_0000);
        checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_instr", instr, 32'd0);
        checkOutput("rst_instr_pc", instr_pc, 32'd0);
        checkOutput("rst_fault", 32'(fault), 32'd0);
        checkOutput("rst_fetch_count", fetch_count, 32'd0);
        expFetchCount = 0;
        expQ.delete();
        rst_n = 1'b1;
    endtask

    // Wait for a request, check its address, optionally stall it, then accept it.
    // Returns on the falling edge just after acceptance (first WAIT cycle).
    task automatic issueReq(input logic [31:0] expAddr, input int reqDelay);
        int n = 0;
        while (imem_req_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("req_valid_seen", 32'(imem_req_valid), 32'd1);
        checkOutput("req_addr", imem_addr, expAddr);
        for (int i = 0; i < reqDelay; i++) begin
            @(negedge clk);
            checkOutput("req_stall_valid", 32'(imem_req_valid), 32'd1);
            checkOutput("req_stall_addr", imem_addr, expAddr);
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        checkOutput("req_dropped", 32'(imem_req_valid), 32'd0);
    endtask

    // Drive one response after 'delay' idle WAIT cycles.
    task automatic respond(input logic [31:0] addr, input logic [31:0] data, input logic err, input int delay);
        expect_t e;
        repeat (delay) @(negedge clk);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        imem_rsp_err   = err;
        if (!err) begin
            e.instr = data;
            e.pc    = addr;
            expQ.push_back(e);
        end
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        imem_rsp_data  = $urandom;
    endtask

    // Pop the scoreboard against the presented instruction, stall, then hand it off.
    task automatic completeInstr(input int holdCycles, input logic br, input logic jp);
        expect_t e;
        int n = 0;
        while (instr_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("instr_valid_seen", 32'(instr_valid), 32'd1);
        if (expQ.size() == 0) begin
            checkOutput("scoreboard_nonempty", 32'd0, 32'd1);
            e = '0;
        end else begin
            e = expQ.pop_front();
        end
        checkOutput("instr", instr, e.instr);
        checkOutput("instr_pc", instr_pc, e.pc);
        for (int i = 0; i < holdCycles; i++) begin
            branch_taken = 1'($urandom_range(0, 1));
            jump_taken   = 1'($urandom_range(0, 1));
            @(negedge clk);
            checkOutput("hold_instr_valid", 32'(instr_valid), 32'd1);
            checkOutput("hold_instr", instr, e.instr);
            checkOutput("hold_instr_pc", instr_pc, e.pc);
            checkOutput("hold_no_req", 32'(imem_req_valid), 32'd0);
        end
        instr_ready  = 1'b1;
        branch_taken = br;
        jump_taken   = jp;
        @(negedge clk);
        instr_ready  = 1'b0;
        branch_taken = 1'b0;
        jump_taken   = 1'b0;
        expFetchCount++;
        checkOutput("fetch_count", fetch_count, 32'(expFetchCount));
        checkOutput("req_after_hs", 32'(imem_req_valid), 32'd1);
        checkOutput("instr_valid_drop", 32'(instr_valid), 32'd0);
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input logic br, input logic jp, input int holdCycles);
        issueReq(addr, 0);
        respond(addr, data, 1'b0, 0);
        completeInstr(holdCycles, br, jp);
    endtask

    initial begin
        imem_rsp_data = 32'd0;
        doReset();

        // Sequential fetch, with one decode stall of 3 cycles.
        applyStimulus(32'h0000_0000, 32'h0000_0020, 1'b0, 1'b0, 0);
        applyStimulus(32'h0000_0004, 32'h0000_0020, 1'b0, 1'b0, 3);
        checkOutput("fetch_count_two", fetch_count, 32'd2);
        // j to 0x10
        applyStimulus(32'h0000_0008, 32'h0800_0004, 1'b0, 1'b1, 0);
        // beq back by one word when taken, fall through when not
        applyStimulus(32'h0000_0010, 32'h1000_FFFF, 1'b1, 1'b0, 0);
        applyStimulus(32'h0000_0010, 32'h1000_FFFF, 1'b0, 1'b0, 0);
        // j to the top of region 0, then a forward branch across the 256 MB boundary
        applyStimulus(32'h0000_0014, 32'h0BFF_FFFE, 1'b0, 1'b1, 0);
        applyStimulus(32'h0FFF_FFF8, 32'h1000_0003, 1'b1, 1'b0, 0);
        // j in region 1, then j with branch also asserted
        applyStimulus(32'h1000_0008, 32'h0800_0040, 1'b0, 1'b1, 0);
        applyStimulus(32'h1000_0100, 32'h0800_0040, 1'b1, 1'b1, 0);

        // Request stalled 5 cycles, then an error response.
        issueReq(32'h1000_0100, 5);
        respond(32'h1000_0100, 32'hDEAD_BEEF, 1'b1, 0);
        checkOutput("err_fault", 32'(fault), 32'd1);
        for (int i = 0; i < 6; i++) begin
            imem_rsp_valid = 1'($urandom_range(0, 1));
            imem_req_ready = 1'b1;
            instr_ready    = 1'b1;
            @(negedge clk);
            checkOutput("fault_sticky", 32'(fault), 32'd1);
            checkOutput("fault_no_req", 32'(imem_req_valid), 32'd0);
            checkOutput("fault_no_instr", 32'(instr_valid), 32'd0);
            checkOutput("fault_pc_frozen", imem_addr, 32'h1000_0100);
        end
        doReset();

        // No response: fault only after 16 WAIT cycles.
        issueReq(32'h0000_0000, 0);
        for (int i = 0; i < 15; i++) begin
            checkOutput("timeout_not_yet", 32'(fault), 32'd0);
            @(negedge clk);
        end
        checkOutput("timeout_cycle16", 32'(fault), 32'd0);
        @(negedge clk);
        checkOutput("timeout_fault", 32'(fault), 32'd1);
        doReset();

        // Response on the 16th WAIT cycle still wins.
        issueReq(32'h0000_0000, 0);
        respond(32'h0000_0000, 32'h0000_0020, 1'b0, 15);
        checkOutput("late_rsp_no_fault", 32'(fault), 32'd0);
        completeInstr(0, 1'b0, 1'b0);

        // Reset while waiting, then a stale response lands in REQ.
        issueReq(32'h0000_0004, 0);
        doReset();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0BAD_0BAD;
        repeat (2) @(negedge clk);
        imem_rsp_valid = 1'b0;
        checkOutput("stale_rsp_ignored", 32'(instr_valid), 32'd0);
        applyStimulus(32'h0000_0000, 32'h0000_0020, 1'b0, 1'b0, 0);
        checkOutput("post_reset_next", imem_addr, 32'h0000_0004);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
